seven_seg_scan_driver: RTL and testbench

Parametrised, time-multiplexed seven-segment display driver for the countdown clock and its successors. Accepts NUM_DIGITS packed 4-bit digit values, snapshots them once per display frame, scans one digit per refresh slot with anti-ghosting guard time, and drives shared active-low segment lines plus per-digit anode enables. Adds hex glyphs, per-digit blanking, decimal points and leading-zero suppression.

---
 rtl/seg7_pkg.sv | 43 ++++
 rtl/seg7_decode.sv | 36 +++
 rtl/seven_seg_scan_driver.sv | 166 ++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment display path.
//   seg_t       - segment bit order {a,b,c,d,e,f,g}; a is bit 6, g is bit 0.
//                 All glyphs are active-low (0 = segment lit).
//   digit_t     - one 4-bit digit value.
//   GLYPH_*     - decoded glyphs for 0-9, A-F and the blank glyph.
//   idx_width() - scan index width, never below 1 bit.
package seg7_pkg;

  typedef logic [3:0] digit_t;

  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
    logic e;
    logic f;
    logic g;
  } seg_t;

  localparam seg_t GLYPH_0     = 7'b0000001;
  localparam seg_t GLYPH_1     = 7'b1001111;
  localparam seg_t GLYPH_2     = 7'b0010010;
  localparam seg_t GLYPH_3     = 7'b0000110;
  localparam seg_t GLYPH_4     = 7'b1001100;
  localparam seg_t GLYPH_5     = 7'b0100100;
  localparam seg_t GLYPH_6     = 7'b0100000;
  localparam seg_t GLYPH_7     = 7'b0001101;
  localparam seg_t GLYPH_8     = 7'b0000000;
  localparam seg_t GLYPH_9     = 7'b0000100;
  localparam seg_t GLYPH_A     = 7'b0001000;
  localparam seg_t GLYPH_B     = 7'b1100000;
  localparam seg_t GLYPH_C     = 7'b0110001;
  localparam seg_t GLYPH_D     = 7'b1000010;
  localparam seg_t GLYPH_E     = 7'b0110000;
  localparam seg_t GLYPH_F     = 7'b0111000;
  localparam seg_t GLYPH_BLANK = 7'b1111111;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational digit-to-glyph decoder.
//   value  - 4-bit digit value
//   hex_en - 1: 10-15 decode as A,b,C,d,E,F; 0: 10-15 decode blank
//   glyph  - active-low segments {a..g}
module seg7_decode
  import seg7_pkg::*;
(
  input  digit_t value,
  input  logic   hex_en,
  output seg_t   glyph
);

  always_comb begin
    glyph = GLYPH_BLANK;
    case (value)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = hex_en ? GLYPH_A : GLYPH_BLANK;
      4'hB: glyph = hex_en ? GLYPH_B : GLYPH_BLANK;
      4'hC: glyph = hex_en ? GLYPH_C : GLYPH_BLANK;
      4'hD: glyph = hex_en ? GLYPH_D : GLYPH_BLANK;
      4'hE: glyph = hex_en ? GLYPH_E : GLYPH_BLANK;
      4'hF: glyph = hex_en ? GLYPH_F : GLYPH_BLANK;
      default: glyph = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed seven-segment display driver.
//   clk         - system clock
//   reset       - asynchronous, active-high reset
//   enable      - 1 scans the display, 0 freezes the scan and blanks outputs
//   digits_in   - packed digits, digit i at [4i+3:4i], digit 0 least significant
//   dp_in       - per-digit decimal point request
//   blank_in    - per-digit force-dark (decimal point included)
//   seg_n       - shared segments {a..g}, active-low, registered
//   dp_n        - shared decimal point, active-low, registered
//   an_n        - per-digit anode enables, active-low, registered
//   frame_start - one-cycle pulse in the cycle the new snapshot is visible
// Inputs are captured only when the scan wraps from the top digit back to
// digit 0, so a frame never mixes old and new digit values.
module seven_seg_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int GUARD       = 2,
  parameter int HEX_MODE    = 0,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_start
);

  localparam int              DW        = $clog2(SCAN_DIV);
  localparam int              IW        = idx_width(NUM_DIGITS);
  localparam logic [DW-1:0]   DIV_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [DW:0]     GUARD_LEN = (DW + 1)'(GUARD);
  localparam logic [IW-1:0]   IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic            HEX_EN    = (HEX_MODE != 0);
  localparam logic            LZ_EN     = (LZ_SUPPRESS != 0);

  logic [DW-1:0]         div_q, div_d, eff_div;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  en_q;
  digit_t                snap_val_q [NUM_DIGITS];
  digit_t                snap_val_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] snap_dp_q, snap_dp_d;
  logic [NUM_DIGITS-1:0] snap_blank_q, snap_blank_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  fs_q, fs_d;

  logic                  restart, tick, wrap, run;
  logic [NUM_DIGITS-1:0] supp;
  digit_t                cur_val;
  seg_t                  cur_glyph;

  // The first enabled cycle after a pause behaves as divider 0 of the held
  // slot, so the slot restarts with a full guard interval.
  assign restart = enable & ~en_q;
  assign eff_div = restart ? '0 : div_q;
  assign tick    = enable & (eff_div == DIV_LAST);
  assign wrap    = tick & (idx_q == IDX_LAST);

  always_comb begin
    div_d        = div_q;
    idx_d        = idx_q;
    snap_val_d   = snap_val_q;
    snap_dp_d    = snap_dp_q;
    snap_blank_d = snap_blank_q;
    if (enable) begin
      div_d = tick ? '0 : eff_div + 1'b1;
    end
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end
    if (wrap) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        snap_val_d[k] = digits_in[4*k +: 4];
      end
      snap_dp_d    = dp_in;
      snap_blank_d = blank_in;
    end
  end

  // Leading-zero suppression: walk from the most significant digit down,
  // keeping "run" high while every digit seen so far is zero or blanked.
  always_comb begin
    run  = 1'b1;
    supp = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (LZ_EN && (k > 0) && run && (snap_val_q[k] == 4'd0)) begin
        supp[k] = 1'b1;
      end
      run = run & ((snap_val_q[k] == 4'd0) | snap_blank_q[k]);
    end
  end

  assign cur_val = snap_val_q[idx_q];

  seg7_decode u_decode (
    .value  (cur_val),
    .hex_en (HEX_EN),
    .glyph  (cur_glyph)
  );

  // Outputs are computed from the current index/divider and registered, so
  // the display trails the scan state by one cycle; the guard window covers
  // the first GUARD cycles of each displayed slot.
  always_comb begin
    seg_d = '1;
    dp_d  = 1'b1;
    an_d  = '1;
    fs_d  = 1'b0;
    if (enable) begin
      fs_d = wrap;
      if (!snap_blank_q[idx_q]) begin
        dp_d = ~snap_dp_q[idx_q];
        if (!supp[idx_q]) begin
          seg_d = cur_glyph;
        end
      end
      if ({1'b0, eff_div} >= GUARD_LEN) begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          an_d[k] = (idx_q != IW'(k));
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q        <= '0;
      idx_q        <= '0;
      en_q         <= 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        snap_val_q[k] <= '0;
      end
      snap_dp_q    <= '0;
      snap_blank_q <= '1;
      seg_q        <= '1;
      dp_q         <= 1'b1;
      an_q         <= '1;
      fs_q         <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      en_q         <= enable;
      snap_val_q   <= snap_val_d;
      snap_dp_q    <= snap_dp_d;
      snap_blank_q <= snap_blank_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      fs_q         <= fs_d;
    end
  end

  assign seg_n       = seg_q;
  assign dp_n        = dp_q;
  assign an_n        = an_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
module tb_seven_seg_scan_driver;

  localparam int N  = 4;
  localparam int SD = 8;
  localparam int GD = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic            enable = 1'b1;
  logic [4*N-1:0]  digits_in = '0;
  logic [N-1:0]    dp_in = '0;
  logic [N-1:0]    blank_in = '0;

  logic [6:0]   seg_n, seg_h;
  logic         dp_n, dp_h;
  logic [N-1:0] an_n, an_h;
  logic         frame_start, fs_h;

  seven_seg_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .GUARD(GD),
                          .HEX_MODE(0), .LZ_SUPPRESS(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .digits_in(digits_in),
    .dp_in(dp_in), .blank_in(blank_in), .seg_n(seg_n), .dp_n(dp_n),
    .an_n(an_n), .frame_start(frame_start));

  seven_seg_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(SD), .GUARD(GD),
                          .HEX_MODE(1), .LZ_SUPPRESS(0)) dut_h (
    .clk(clk), .reset(reset), .enable(enable), .digits_in(digits_in),
    .dp_in(dp_in), .blank_in(blank_in), .seg_n(seg_h), .dp_n(dp_h),
    .an_n(an_h), .frame_start(fs_h));

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp_v, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Scan position p = slot*SD + offset within the frame; outputs after an
  // enabled edge show the position held before that edge.
  logic [6:0] gl [16];
  int         p = 0;
  bit         m_en_prev = 1'b0;
  logic [15:0] m_dig = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  m_blank = 4'hF;
  logic [6:0]  e_seg = 7'h7F, e_segh = 7'h7F;
  logic        e_dpn = 1'b1, e_dpnh = 1'b1;
  logic [3:0]  e_an = 4'hF;
  logic        e_fs = 1'b0;

  initial begin
    gl[0] = 7'b0000001; gl[1] = 7'b1001111; gl[2] = 7'b0010010; gl[3] = 7'b0000110;
    gl[4] = 7'b1001100; gl[5] = 7'b0100100; gl[6] = 7'b0100000; gl[7] = 7'b0001101;
    gl[8] = 7'b0000000; gl[9] = 7'b0000100; gl[10] = 7'b0001000; gl[11] = 7'b1100000;
    gl[12] = 7'b0110001; gl[13] = 7'b1000010; gl[14] = 7'b0110000; gl[15] = 7'b0111000;
  end

  function automatic void exp_digit(input int k, input bit hex, input bit lz,
                                    output logic [6:0] seg, output logic dpn);
    logic [3:0] v;
    bit supp;
    v = m_dig[k*4 +: 4];
    if (m_blank[k]) begin
      seg = 7'h7F;
      dpn = 1'b1;
    end else begin
      supp = lz && (k > 0) && (v == 4'd0);
      for (int j = k + 1; j < N; j++) begin
        if (!(m_dig[j*4 +: 4] == 4'd0 || m_blank[j])) supp = 1'b0;
      end
      dpn = ~m_dp[k];
      if (supp || (v > 4'd9 && !hex)) seg = 7'h7F;
      else seg = gl[v];
    end
  endfunction

  initial begin
    int slot, off;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        p = 0; m_en_prev = 1'b0;
        m_dig = '0; m_dp = '0; m_blank = 4'hF;
        e_seg = 7'h7F; e_segh = 7'h7F; e_dpn = 1'b1; e_dpnh = 1'b1;
        e_an = 4'hF; e_fs = 1'b0;
      end else if (!enable) begin
        e_seg = 7'h7F; e_segh = 7'h7F; e_dpn = 1'b1; e_dpnh = 1'b1;
        e_an = 4'hF; e_fs = 1'b0;
        m_en_prev = 1'b0;
      end else begin
        if (!m_en_prev) p = (p / SD) * SD;
        slot = p / SD;
        off  = p % SD;
        exp_digit(slot, 1'b0, 1'b1, e_seg, e_dpn);
        exp_digit(slot, 1'b1, 1'b0, e_segh, e_dpnh);
        e_an = (off >= GD) ? ~(4'b0001 << slot) : 4'hF;
        e_fs = (p == N*SD - 1);
        if (e_fs) begin
          m_dig = digits_in; m_dp = dp_in; m_blank = blank_in;
        end
        p = (p + 1) % (N*SD);
        m_en_prev = 1'b1;
      end
    end
  end

  // continuous comparison of both instances against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("seg", seg_n, e_seg);
        chk("dp", dp_n, e_dpn);
        chk("an", an_n, e_an);
        chk("fs", frame_start, e_fs);
        chk("seg_hex", seg_h, e_segh);
        chk("dp_hex", dp_h, e_dpnh);
        chk("an_hex", an_h, e_an);
        chk("fs_hex", fs_h, e_fs);
      end
    end
  end

  // ---------------- table vectors ----------------
  typedef struct packed {
    logic [15:0]     dig;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic [3:0][6:0] seg;   // [s] = expected seg_n in slot s, HEX off / LZ on
    logic [3:0]      dpn;
    logic [3:0][6:0] segh;  // HEX on / LZ off
    logic [3:0]      dpnh;
  } vec_t;

  vec_t vecs [5];

  // ---------------- driver tasks ----------------
  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 100);
    chk("frame_start_seen", frame_start, 1'b1);
  endtask

  task automatic set_inputs(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    digits_in = d;
    dp_in     = dp;
    blank_in  = bl;
  endtask

  initial begin
    int n;
    logic [3:0] exp_an;
    #1 reset = 1'b1;
    chk_on = 1'b1;
    #1;
    chk("rst_seg", seg_n, 7'h7F);
    chk("rst_an", an_n, 4'hF);
    chk("rst_dp", dp_n, 1'b1);
    chk("rst_fs", frame_start, 1'b0);

    vecs[0] = '{16'h1234, 4'b0000, 4'b0000,
                {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'b1111,
                {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'b1111};
    vecs[1] = '{16'h0070, 4'b0100, 4'b0000,
                {7'h7F, 7'h7F, 7'b0001101, 7'b0000001}, 4'b1011,
                {7'b0000001, 7'b0000001, 7'b0001101, 7'b0000001}, 4'b1011};
    vecs[2] = '{16'hB0A5, 4'b0000, 4'b0000,
                {7'h7F, 7'b0000001, 7'h7F, 7'b0100100}, 4'b1111,
                {7'b1100000, 7'b0000001, 7'b0001000, 7'b0100100}, 4'b1111};
    vecs[3] = '{16'h0008, 4'b1001, 4'b1000,
                {7'h7F, 7'h7F, 7'h7F, 7'b0000000}, 4'b1110,
                {7'h7F, 7'b0000001, 7'b0000001, 7'b0000000}, 4'b1110};
    vecs[4] = '{16'hCDEF, 4'b0010, 4'b0100,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b1101,
                {7'b0110001, 7'h7F, 7'b0110000, 7'b0111000}, 4'b1101};

    // reset release with data present: first frame dark, load after 32 edges
    repeat (3) @(negedge clk);
    set_inputs(16'h1234, 4'b0000, 4'b0000);
    reset = 1'b0;
    wait_fs(n);
    chk("first_fs_cycle", n, 32);

    // table: load each vector, scramble inputs mid-frame, check every slot
    for (int i = 0; i < 5; i++) begin
      set_inputs(vecs[i].dig, vecs[i].dp, vecs[i].blank);
      wait_fs(n);
      set_inputs(16'($urandom), 4'($urandom), 4'($urandom));
      repeat (4) @(negedge clk);
      for (int s = 0; s < N; s++) begin
        exp_an = ~(4'b0001 << s);
        chk("tab_seg", seg_n, vecs[i].seg[s]);
        chk("tab_dp", dp_n, vecs[i].dpn[s]);
        chk("tab_an", an_n, exp_an);
        chk("tab_seg_hex", seg_h, vecs[i].segh[s]);
        chk("tab_dp_hex", dp_h, vecs[i].dpnh[s]);
        if (s < N - 1) repeat (8) @(negedge clk);
      end
      if (i == 4) set_inputs(16'h1234, 4'b0000, 4'b0000);
    end

    // enable low for 20 cycles in the middle of slot 1
    wait_fs(n);
    repeat (12) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_seg", seg_n, 7'h7F);
    chk("dis_an", an_n, 4'hF);
    chk("dis_dp", dp_n, 1'b1);
    repeat (19) @(negedge clk);
    chk("dis_an_end", an_n, 4'hF);
    enable = 1'b1;
    @(negedge clk);
    chk("reen_guard1", an_n, 4'hF);
    chk("reen_seg", seg_n, 7'b0000110);
    @(negedge clk);
    chk("reen_guard2", an_n, 4'hF);
    @(negedge clk);
    chk("reen_resume", an_n, 4'b1101);

    // asynchronous reset during slot 2
    wait_fs(n);
    repeat (20) @(negedge clk);
    chk("pre_rst_an", an_n, 4'b1011);
    #1 reset = 1'b1;
    #1;
    chk("async_seg", seg_n, 7'h7F);
    chk("async_an", an_n, 4'hF);
    chk("async_dp", dp_n, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    wait_fs(n);
    chk("recover_fs_cycle", n, 32);

    // randomized phase against the model
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        for (int k = 0; k < N; k++) begin
          digits_in[k*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
        end
        dp_in    = 4'($urandom);
        blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      end
      if (!enable) enable = ($urandom_range(0, 3) != 0);
      else         enable = ($urandom_range(0, 24) != 0);
    end
    enable = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
